// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle: register indices, hazard/miss status in, forwarding and stall/flush enables out.
// With HAZARD_PERF_EN defined the bundle also carries the three 32-bit performance counters.
interface hazard_controller_if;
  logic [4:0]  rs1D;
  logic [4:0]  rs2D;
  logic [4:0]  rs1E;
  logic [4:0]  rs2E;
  logic [4:0]  rdE;
  logic [4:0]  rdM;
  logic [4:0]  rdW;
  logic        regWriteM;
  logic        regWriteW;
  logic        loadE;
  logic        branchTakenE;
  logic        jumpE;
  logic        memReqM;
  logic        dcacheHitM;
  logic        refillDoneM;
  logic [1:0]  forwardAE;
  logic [1:0]  forwardBE;
  logic        stallF;
  logic        stallD;
  logic        stallE;
  logic        stallM;
  logic        flushD;
  logic        flushE;
  logic        flushW;
  logic        missBusy;
  logic        timeoutErr;
`ifdef HAZARD_PERF_EN
  logic [31:0] perfMissCycles;
  logic [31:0] perfLoadUse;
  logic [31:0] perfFlush;
`endif

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    output regWriteM, regWriteW, loadE, branchTakenE, jumpE,
    output memReqM, dcacheHitM, refillDoneM,
    input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
    input  flushD, flushE, flushW, missBusy, timeoutErr
`ifdef HAZARD_PERF_EN
    , input perfMissCycles, perfLoadUse, perfFlush
`endif
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    input  regWriteM, regWriteW, loadE, branchTakenE, jumpE,
    input  memReqM, dcacheHitM, refillDoneM,
    output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
    output flushD, flushE, flushW, missBusy, timeoutErr
`ifdef HAZARD_PERF_EN
    , output perfMissCycles, perfLoadUse, perfFlush
`endif
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage RV32I core: EX forwarding, load-use/redirect hazards and D-cache miss freeze.
// Optional HAZARD_PERF_EN adds wrapping 32-bit counters for miss, load-use and flush cycles.
module hazard_controller #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input logic             clk,
  input logic             rst_n,
  hazard_controller_if.slave hz
);

  typedef enum logic {IDLE, MISS_WAIT} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             timeout_err;
  logic             miss_stall;
  logic             lw_stall;
  logic             ctrl_flush;

  // MEM result is younger than WB, so it wins when both target the same register.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic wr_m,
                                         input logic [4:0] rd_w, input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  always_comb begin
    hz.forwardAE = fwd_sel(hz.rs1E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW);
    hz.forwardBE = fwd_sel(hz.rs2E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW);
  end

  assign lw_stall   = hz.loadE && (hz.rdE != 5'd0) && ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
  assign ctrl_flush = hz.branchTakenE || hz.jumpE;

  always_comb begin
    state_nxt  = state;
    miss_stall = 1'b0;
    case (state)
      IDLE: begin
        if (hz.memReqM && !hz.dcacheHitM) begin
          state_nxt  = MISS_WAIT;
          miss_stall = 1'b1;
        end
      end
      MISS_WAIT: begin
        // Hit status is meaningless while the refill is outstanding.
        if (hz.refillDoneM) state_nxt  = IDLE;
        else                miss_stall = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A frozen branch keeps branchTakenE asserted, so its flush lands in the release cycle.
  always_comb begin
    hz.stallF = 1'b0;
    hz.stallD = 1'b0;
    hz.stallE = 1'b0;
    hz.stallM = 1'b0;
    hz.flushD = 1'b0;
    hz.flushE = 1'b0;
    hz.flushW = 1'b0;
    if (miss_stall) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.stallM = 1'b1;
      hz.flushW = 1'b1;
    end else if (ctrl_flush) begin
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
    end else if (lw_stall) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.flushE = 1'b1;
    end
  end

  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == MISS_WAIT) begin
        cnt <= '0;
      end else if (state == MISS_WAIT) begin
        cnt <= cnt_inc;
        if (cnt_inc >= TIMEOUT_VAL) timeout_err <= 1'b1;
      end
    end
  end

  assign hz.missBusy   = (state == MISS_WAIT);
  assign hz.timeoutErr = timeout_err;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_miss, perf_lu, perf_fl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_miss <= '0;
      perf_lu   <= '0;
      perf_fl   <= '0;
    end else begin
      if (miss_stall)                           perf_miss <= perf_miss + 32'd1;
      if (!miss_stall && !ctrl_flush && lw_stall) perf_lu <= perf_lu + 32'd1;
      if (!miss_stall && ctrl_flush)            perf_fl   <= perf_fl + 32'd1;
    end
  end

  assign hz.perfMissCycles = perf_miss;
  assign hz.perfLoadUse    = perf_lu;
  assign hz.perfFlush      = perf_fl;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (TIMEOUT_CYCLES=16): forwarding, load-use, redirects, miss freeze, timeout, async reset.
module tb_hazard_controller;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  hazard_controller_if hz();

  hazard_controller #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
  logic [6:0]  ctl;
  logic [12:0] all_outs;
  assign ctl      = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushD, hz.flushE, hz.flushW};
  assign all_outs = {hz.forwardAE, hz.forwardBE, ctl, hz.missBusy, hz.timeoutErr};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    hz.rs1D = 0; hz.rs2D = 0; hz.rs1E = 0; hz.rs2E = 0;
    hz.rdE = 0; hz.rdM = 0; hz.rdW = 0;
    hz.regWriteM = 0; hz.regWriteW = 0; hz.loadE = 0;
    hz.branchTakenE = 0; hz.jumpE = 0;
    hz.memReqM = 0; hz.dcacheHitM = 0; hz.refillDoneM = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    #1;
    n_cmp++;
    if (all_outs !== 13'd0) begin
      n_err++; $display("FAIL reset_outs got=%b exp=%b", all_outs, 13'd0);
    end
    rst_n = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (all_outs !== 13'd0) begin
      n_err++; $display("FAIL post_reset_outs got=%b exp=%b", all_outs, 13'd0);
    end
  endtask

  task automatic test_forwarding;
    clear_inputs();
    hz.rdM = 5; hz.regWriteM = 1; hz.rdW = 5; hz.regWriteW = 1; hz.rs1E = 5; hz.rs2E = 9;
    #1;
    n_cmp++;
    if (hz.forwardAE !== 2'b10) begin n_err++; $display("FAIL fwdA_mem_prio got=%b exp=10", hz.forwardAE); end
    n_cmp++;
    if (hz.forwardBE !== 2'b00) begin n_err++; $display("FAIL fwdB_nomatch got=%b exp=00", hz.forwardBE); end
    hz.rdM = 6;
    #1;
    n_cmp++;
    if (hz.forwardAE !== 2'b01) begin n_err++; $display("FAIL fwdA_wb got=%b exp=01", hz.forwardAE); end
    hz.rs2E = 6;
    #1;
    n_cmp++;
    if (hz.forwardBE !== 2'b10) begin n_err++; $display("FAIL fwdB_mem got=%b exp=10", hz.forwardBE); end
    hz.regWriteM = 0;
    #1;
    n_cmp++;
    if (hz.forwardBE !== 2'b00) begin n_err++; $display("FAIL fwdB_nowrite got=%b exp=00", hz.forwardBE); end
    hz.rs1E = 0; hz.rdM = 0; hz.rdW = 0; hz.regWriteM = 1;
    #1;
    n_cmp++;
    if (hz.forwardAE !== 2'b00) begin n_err++; $display("FAIL fwdA_x0 got=%b exp=00", hz.forwardAE); end
    clear_inputs();
  endtask

  task automatic test_load_use;
    clear_inputs();
    tick();
    hz.loadE = 1; hz.rdE = 7; hz.rs2D = 7; hz.rs1D = 3;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ctl !== 7'b1100010) begin n_err++; $display("FAIL load_use_cyc%0d got=%b exp=%b", i, ctl, 7'b1100010); end
      tick();
    end
    hz.loadE = 0;
    #1;
    n_cmp++;
    if (ctl !== 7'b0000000) begin n_err++; $display("FAIL load_use_release got=%b exp=%b", ctl, 7'b0000000); end
    hz.loadE = 1; hz.rdE = 0; hz.rs1D = 0; hz.rs2D = 0;
    #1;
    n_cmp++;
    if (ctl !== 7'b0000000) begin n_err++; $display("FAIL load_use_x0 got=%b exp=%b", ctl, 7'b0000000); end
    clear_inputs();
  endtask

  task automatic test_branch;
    clear_inputs();
    hz.branchTakenE = 1;
    #1;
    n_cmp++;
    if (ctl !== 7'b0000110) begin n_err++; $display("FAIL branch_flush got=%b exp=%b", ctl, 7'b0000110); end
    hz.branchTakenE = 0; hz.jumpE = 1;
    #1;
    n_cmp++;
    if (ctl !== 7'b0000110) begin n_err++; $display("FAIL jump_flush got=%b exp=%b", ctl, 7'b0000110); end
    hz.loadE = 1; hz.rdE = 4; hz.rs1D = 4;
    #1;
    n_cmp++;
    if (ctl !== 7'b0000110) begin n_err++; $display("FAIL redirect_over_lw got=%b exp=%b", ctl, 7'b0000110); end
    clear_inputs();
  endtask

  // Detect cycle + 20 waiting cycles frozen, refill in the following cycle.
  task automatic test_miss(input logic br);
    int stall_cyc;
    int busy_cyc;
    clear_inputs();
    tick();
    stall_cyc = 0;
    busy_cyc  = 0;
    hz.branchTakenE = br;
    hz.memReqM = 1; hz.dcacheHitM = 0;
    for (int i = 0; i < 21; i++) begin
      #1;
      if (ctl === 7'b1111001) stall_cyc++;
      if (hz.missBusy === 1'b1) busy_cyc++;
      tick();
      hz.memReqM = 0;
    end
    n_cmp++;
    if (stall_cyc != 21) begin n_err++; $display("FAIL miss_stall_cycles br=%0b got=%0d exp=21", br, stall_cyc); end
    n_cmp++;
    if (busy_cyc != 20) begin n_err++; $display("FAIL miss_busy_cycles br=%0b got=%0d exp=20", br, busy_cyc); end
    hz.refillDoneM = 1;
    #1;
    n_cmp++;
    if (ctl !== (br ? 7'b0000110 : 7'b0000000)) begin
      n_err++; $display("FAIL miss_refill_ctl br=%0b got=%b exp=%b", br, ctl, (br ? 7'b0000110 : 7'b0000000));
    end
    n_cmp++;
    if (hz.missBusy !== 1'b1) begin n_err++; $display("FAIL miss_refill_busy got=%b exp=1", hz.missBusy); end
    tick();
    hz.refillDoneM = 0; hz.branchTakenE = 0;
    #1;
    n_cmp++;
    if ({hz.missBusy, ctl} !== 8'd0) begin n_err++; $display("FAIL miss_idle got=%b exp=%b", {hz.missBusy, ctl}, 8'd0); end
    clear_inputs();
  endtask

  task automatic test_back_to_back;
    clear_inputs();
    hz.memReqM = 1; hz.dcacheHitM = 1;
    #1;
    n_cmp++;
    if (ctl !== 7'b0000000) begin n_err++; $display("FAIL hit_no_stall got=%b exp=%b", ctl, 7'b0000000); end
    hz.dcacheHitM = 0;
    tick();
    hz.memReqM = 0;
    hz.loadE = 1; hz.rdE = 7; hz.rs1D = 7; hz.dcacheHitM = 1;
    #1;
    n_cmp++;
    if ({hz.missBusy, ctl} !== 8'b1_1111001) begin
      n_err++; $display("FAIL wait_masks_lw_hit got=%b exp=%b", {hz.missBusy, ctl}, 8'b1_1111001);
    end
    hz.loadE = 0;
    tick();
    hz.refillDoneM = 1;
    #1;
    n_cmp++;
    if (ctl !== 7'b0000000) begin n_err++; $display("FAIL b2b_refill1 got=%b exp=%b", ctl, 7'b0000000); end
    tick();
    hz.refillDoneM = 0; hz.memReqM = 1; hz.dcacheHitM = 0;
    #1;
    n_cmp++;
    if ({hz.missBusy, ctl} !== 8'b0_1111001) begin
      n_err++; $display("FAIL b2b_second_detect got=%b exp=%b", {hz.missBusy, ctl}, 8'b0_1111001);
    end
    tick();
    hz.memReqM = 0; hz.refillDoneM = 1;
    #1;
    n_cmp++;
    if ({hz.missBusy, ctl} !== 8'b1_0000000) begin
      n_err++; $display("FAIL b2b_refill2 got=%b exp=%b", {hz.missBusy, ctl}, 8'b1_0000000);
    end
    tick();
    hz.refillDoneM = 0;
    #1;
    n_cmp++;
    if (hz.missBusy !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b exp=0", hz.missBusy); end
    clear_inputs();
  endtask

  task automatic test_timeout;
    clear_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    hz.memReqM = 1; hz.dcacheHitM = 0;
    tick();
    hz.memReqM = 0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      n_cmp++;
      if (hz.timeoutErr !== (k >= 16)) begin
        n_err++; $display("FAIL timeout_wait%0d got=%b exp=%b", k, hz.timeoutErr, (k >= 16));
      end
    end
    n_cmp++;
    if (ctl !== 7'b1111001) begin n_err++; $display("FAIL timeout_still_waiting got=%b exp=%b", ctl, 7'b1111001); end
    hz.refillDoneM = 1;
    tick();
    hz.refillDoneM = 0;
    repeat (2) tick();
    n_cmp++;
    if ({hz.missBusy, hz.timeoutErr} !== 2'b01) begin
      n_err++; $display("FAIL timeout_sticky got=%b exp=01", {hz.missBusy, hz.timeoutErr});
    end
    clear_inputs();
  endtask

  task automatic test_async_reset;
    clear_inputs();
    hz.memReqM = 1; hz.dcacheHitM = 0;
    tick();
    hz.memReqM = 0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({hz.missBusy, hz.timeoutErr, ctl} !== 9'd0) begin
      n_err++; $display("FAIL async_reset got=%b exp=%b", {hz.missBusy, hz.timeoutErr, ctl}, 9'd0);
    end
    #1;
    rst_n = 1'b1;
    tick();
    #1;
    n_cmp++;
    if ({hz.missBusy, ctl} !== 8'd0) begin
      n_err++; $display("FAIL async_reset_idle got=%b exp=%b", {hz.missBusy, ctl}, 8'd0);
    end
    hz.memReqM = 1; hz.dcacheHitM = 0;
    tick();
    hz.memReqM = 0;
    n_cmp++;
    if (hz.missBusy !== 1'b1) begin n_err++; $display("FAIL async_reset_rearm got=%b exp=1", hz.missBusy); end
    clear_inputs();
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_miss(1'b0);
    test_miss(1'b1);
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central pipeline sequencer for the 5-stage RV32I core with data cache.
- Drives the EX-stage operand forwarding selects.
- Detects load-use hazards and applies branch/jump flushes.
- Runs a D-cache miss FSM that freezes the whole pipeline until the refill completes; it sits beside the stage registers and drives all their stall/flush enables.

Parameters:
- TIMEOUT_CYCLES, 1024: MISS_WAIT cycles after which timeoutErr sets.
- CNT_W, 11: width of the miss-wait cycle counter (must hold TIMEOUT_CYCLES).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rs1D  in  5  rs1 of the instruction in ID.
- rs2D  in  5  rs2 of the instruction in ID.
- rs1E  in  5  rs1 of the instruction in EX.
- rs2E  in  5  rs2 of the instruction in EX.
- rdE  in  5  destination register in EX.
- rdM  in  5  destination register in MEM.
- rdW  in  5  destination register in WB.
- regWriteM  in  1  MEM instruction writes the register file.
- regWriteW  in  1  WB instruction writes the register file.
- loadE  in  1  EX instruction is a load.
- branchTakenE  in  1  branch decision from EX.
- jumpE  in  1  JAL/JALR in EX.
- memReqM  in  1  MEM instruction accesses the D-cache.
- dcacheHitM  in  1  D-cache hit for the current MEM access (combinational).
- refillDoneM  in  1  single-cycle pulse: refill complete, data valid this cycle.
- forwardAE  out  2  operand A select: 00 regfile, 10 MEM, 01 WB.
- forwardBE  out  2  operand B select, same encoding.
- stallF  out  1  hold PC.
- stallD  out  1  hold IF/ID.
- stallE  out  1  hold ID/EX.
- stallM  out  1  hold EX/MEM.
- flushD  out  1  clear IF/ID.
- flushE  out  1  clear ID/EX.
- flushW  out  1  insert bubble into MEM/WB.
- missBusy  out  1  FSM in MISS_WAIT.
- timeoutErr  out  1  sticky miss-timeout flag.

Behaviour:
- Reset: FSM=IDLE, counter=0, timeoutErr=0.
  - With all inputs 0, every output is 0.
  - Reset mid-miss aborts to IDLE immediately; all stalls drop asynchronously.
- Forwarding: purely combinational, zero latency, evaluated per operand.
  - Select 10 if regWriteM && rdM!=0 && rdM==rsXE.
  - Else select 01 if regWriteW && rdW!=0 && rdW==rsXE.
  - Else 00.
  - MEM has priority over WB when both match.
  - Forwarding is not gated by stalls.
- Miss stall, combinational: missStall = (IDLE && memReqM && !dcacheHitM) || (MISS_WAIT && !refillDoneM).
- FSM transitions:
  - IDLE -> MISS_WAIT when memReqM && !dcacheHitM.
  - MISS_WAIT -> IDLE on refillDoneM.
  - Hit status is ignored in MISS_WAIT.
  - In the refillDoneM cycle stalls are released and the pipeline advances with refill data.
  - A miss by the next MEM instruction in the cycle after return is detected normally, so back-to-back misses are supported.
- While missStall is high:
  - stallF=stallD=stallE=stallM=1 and flushW=1.
  - flushD=flushE=0, so no flush of frozen registers.
- Load-use, combinational: lwStall = loadE && rdE!=0 && (rdE==rs1D || rdE==rs2D).
  - Applied only when missStall=0: stallF=stallD=1, flushE=1.
- Branch/jump: ctrlFlush = branchTakenE || jumpE, applied only when missStall=0.
  - flushD=1 and flushE=1.
  - If lwStall and ctrlFlush coincide: flushD=1, flushE=1, stallF=stallD=0. The redirect wins and the load-use stall is dropped.
- Deferred flush: a branch resolved while frozen keeps branchTakenE stable in EX. Its flush fires in the stall-release cycle; no extra storage is needed.
- Counter:
  - Cleared on entry to MISS_WAIT; increments each MISS_WAIT cycle; saturates at all-ones.
  - When it reaches TIMEOUT_CYCLES, timeoutErr sets and stays set until reset.
  - The FSM keeps waiting after timeout.
- missBusy = (state==MISS_WAIT).

Optional Feature:
- HAZARD_PERF_EN defined: adds three 32-bit output counters, each wrapping and reset to 0.
  - perfMissCycles: cycles with missStall=1.
  - perfLoadUse: cycles with lwStall applied.
  - perfFlush: cycles with ctrlFlush applied.
- HAZARD_PERF_EN undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Forwarding:
  - Drive rdM=5, regWriteM=1, rdW=5, regWriteW=1, rs1E=5 -> forwardAE=10.
  - Change rdM to 6 -> forwardAE=01.
  - Set rs1E=0 with rdM=rdW=0 -> forwardAE=00.
- Load-use: set loadE=1, rdE=7, rs2D=7 -> stallF=stallD=flushE=1 and flushD=0 for exactly the cycles the condition holds.
- Miss: pulse memReqM=1 with dcacheHitM=0, then raise refillDoneM for one cycle after 20 cycles.
  - All four stalls and flushW are high for 21 cycles, including the detect cycle.
  - missBusy is high for 20 cycles; stalls drop in the refill cycle; the FSM returns to IDLE.
- Branch during miss: hold branchTakenE=1 throughout the miss.
  - flushD/flushE stay 0 until the refillDoneM cycle, then assert exactly in that cycle.
- Timeout: with TIMEOUT_CYCLES=16, enter MISS_WAIT and never refill.
  - timeoutErr rises after 16 wait cycles and stays 1 after a later refillDoneM.
  - Only rst_n low clears it.
- Async reset: assert rst_n=0 mid-MISS_WAIT between clock edges -> all stalls and missBusy go 0 immediately; after release the state is IDLE.
